// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - merges key edges and gravity ticks into one serialized game command stream
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat for left, right and down).
module move_scheduler #(
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_DIV   = 5000000,
  parameter int STEP_DIV  = 2500000,
  parameter int LEVEL_PTS = 10
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_DELAY = 20000000,
  parameter int REPEAT_RATE  = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic [6:0] score,
  input  logic       fail,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic [3:0] level
);

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;
  state_t state, state_nxt;

  // Pending bit i belongs to command code i+1: left, right, rotate, drop, gravity.
  logic [3:0]  keys, key_q, rise;
  logic [4:0]  pend, set, clr, rep;
  logic [31:0] grav_cnt, period, period_new, lvl_raw;
  logic [3:0]  level_nxt;
  logic [2:0]  cmd_sel;
  logic        wrap, halt_now, accept;
  int          period_raw;

  assign keys     = {down, up, right, left};
  assign rise     = keys & ~key_q;
  assign halt_now = fail || (state == HALT);
  assign accept   = (state == ISSUE) && cmd_ready && !fail;
  assign wrap     = (grav_cnt == period - 32'd1);
  assign set      = {wrap, rise} | rep;
  assign clr      = accept ? (5'd1 << (cmd - 3'd1)) : 5'd0;

  // Faster levels may push the raw period negative; clamp in signed arithmetic.
  assign period_raw = TICK_DIV - int'(level) * STEP_DIV;
  assign period_new = (period_raw < MIN_DIV) ? 32'(MIN_DIV) : 32'(period_raw);
  assign lvl_raw    = 32'(score) / 32'(LEVEL_PTS);
  assign level_nxt  = (lvl_raw > 32'd15) ? 4'd15 : lvl_raw[3:0];

  always_comb begin
    cmd_sel = 3'd0;
    if (pend[4])      cmd_sel = 3'd5;
    else if (pend[2]) cmd_sel = 3'd3;
    else if (pend[0]) cmd_sel = 3'd1;
    else if (pend[1]) cmd_sel = 3'd2;
    else if (pend[3]) cmd_sel = 3'd4;
  end

`ifdef AUTO_REPEAT_EN
  logic [31:0] hold_cnt [3];
  logic [2:0]  rk, rep_hit;

  assign rk  = {down, right, left};
  assign rep = {1'b0, rep_hit[2], 1'b0, rep_hit[1], rep_hit[0]};

  always_comb begin
    rep_hit = 3'b000;
    for (int i = 0; i < 3; i++)
      rep_hit[i] = rk[i] && (hold_cnt[i] == 32'(REPEAT_DELAY - 1));
  end

  // After the first repeat the counter restarts one repeat interval short of the delay.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || !rk[i])   hold_cnt[i] <= 32'd0;
      else if (rep_hit[i]) hold_cnt[i] <= 32'(REPEAT_DELAY - REPEAT_RATE);
      else                 hold_cnt[i] <= hold_cnt[i] + 32'd1;
    end
  end
`else
  assign rep = 5'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_q    <= 4'd0;
      pend     <= 5'd0;
      grav_cnt <= 32'd0;
      period   <= 32'(TICK_DIV);
      level    <= 4'd0;
      cmd      <= 3'd0;
    end else begin
      state <= state_nxt;
      key_q <= keys;
      level <= level_nxt;
      if (halt_now) begin
        pend <= 5'd0;
      end else begin
        pend <= (pend & ~clr) | set;
        if (wrap) begin
          grav_cnt <= 32'd0;
          period   <= period_new;
        end else begin
          grav_cnt <= grav_cnt + 32'd1;
        end
      end
      if (state == IDLE && state_nxt == ISSUE) cmd <= cmd_sel;
    end
  end

  always_comb begin
    state_nxt = state;
    if (fail) begin
      state_nxt = HALT;
    end else begin
      case (state)
        IDLE:    if (|pend) state_nxt = ISSUE;
        ISSUE:   if (cmd_ready) state_nxt = IDLE;
        default: state_nxt = HALT;
      endcase
    end
  end

  always_comb begin
    cmd_valid = (state == ISSUE);
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - randomized scoreboard bench for move_scheduler
module tb_move_scheduler;
  localparam int TICK = 100, MIN = 20, STEP = 10, PTS = 10, RD = 30, RR = 8;

  logic clk = 0, rst = 1, left = 0, right = 0, up = 0, down = 0, fail = 0, cmd_ready = 0;
  logic [6:0] score = 0;
  logic cmd_valid;
  logic [2:0] cmd;
  logic [3:0] level;

  move_scheduler #(
    .TICK_DIV(TICK), .MIN_DIV(MIN), .STEP_DIV(STEP), .LEVEL_PTS(PTS)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
`endif
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .up(up), .down(down),
    .score(score), .fail(fail), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int n_acc[6];
  bit started = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: commands pending as a set, gravity as elapsed time against a period.
  typedef struct { int code; int at; } exp_t;
  exp_t expq[$];
  int m_pend[6], m_prev[4], m_hold[4];
  int m_issuing, m_cur, m_halt, m_since, m_per, m_lvl;
  int m_valid_now, m_cmd_now;

  function automatic int per_of(input int lv);
    int p;
    p = TICK - lv * STEP;
    return (p < MIN) ? MIN : p;
  endfunction

  task automatic model_step();
    int k[4];
    int setv[6];
    int clr, pick;
    exp_t e;
    k[0] = left; k[1] = right; k[2] = up; k[3] = down;
    m_valid_now = m_issuing;
    m_cmd_now = m_cur;
    if (rst) begin
      m_halt = 0; m_issuing = 0; m_cur = 0; m_since = 0; m_per = TICK; m_lvl = 0;
      for (int c = 0; c < 6; c++) m_pend[c] = 0;
      for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_hold[i] = 0; end
    end else begin
      if (fail || m_halt) begin
        m_halt = 1;
        m_issuing = 0;
        for (int c = 0; c < 6; c++) m_pend[c] = 0;
      end else begin
        for (int c = 0; c < 6; c++) setv[c] = 0;
        for (int i = 0; i < 4; i++) if (k[i] && !m_prev[i]) setv[i+1] = 1;
`ifdef AUTO_REPEAT_EN
        for (int i = 0; i < 4; i++) begin
          if (i == 2) continue;
          if (k[i]) begin
            m_hold[i]++;
            if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RR == 0)) setv[i+1] = 1;
          end else begin
            m_hold[i] = 0;
          end
        end
`endif
        if (m_since == m_per - 1) begin
          m_since = 0;
          m_per = per_of(m_lvl);
          setv[5] = 1;
        end else begin
          m_since++;
        end
        clr = 0;
        if (m_issuing) begin
          if (cmd_ready) begin
            e.code = m_cur; e.at = cyc;
            expq.push_back(e);
            clr = m_cur;
            m_issuing = 0;
          end
        end else begin
          pick = 0;
          if (m_pend[5])      pick = 5;
          else if (m_pend[3]) pick = 3;
          else if (m_pend[1]) pick = 1;
          else if (m_pend[2]) pick = 2;
          else if (m_pend[4]) pick = 4;
          if (pick != 0) begin m_cur = pick; m_issuing = 1; end
        end
        for (int c = 1; c < 6; c++) m_pend[c] = ((m_pend[c] != 0 && c != clr) || setv[c] != 0) ? 1 : 0;
      end
      for (int i = 0; i < 4; i++) m_prev[i] = k[i];
      m_lvl = (score / PTS > 15) ? 15 : score / PTS;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle output check plus scoreboard pop on every accepted handshake.
  always @(negedge clk) begin
    exp_t e;
    if (started && !rst) begin
      check("valid", cmd_valid, m_valid_now);
      if (cmd_valid && m_valid_now) check("cmd", cmd, m_cmd_now);
      if (cmd_valid && cmd_ready && !fail) begin
        n_acc[cmd]++;
        if (expq.size() == 0) begin
          check("unexpected_accept", cmd, 0);
        end else begin
          e = expq.pop_front();
          check("acc_code", cmd, e.code);
          check("acc_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!cmd_valid && n < bound) begin tick(); n++; end
    if (!cmd_valid) begin
      tests++; fails++;
      $display("FAIL wait_valid timeout after %0d cycles", n);
    end
  endtask

  int n, n0;

  initial begin
    for (int c = 0; c < 6; c++) n_acc[c] = 0;
    started = 1;
    rst = 1;
    repeat (3) tick();
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_level", level, 0);
    rst = 0;
    cmd_ready = 1;

    // First gravity command after reset
    wait_valid(200, n);
    check("first_grav_cycle", n, 101);
    check("first_grav_cmd", cmd, 5);
    check("level0", level, 0);

    // Score-scaled gravity
    score = 35;
    tick();
    check("level3", level, 3);
    wait_valid(200, n); tick();
    wait_valid(200, n);
    check("interval_l3", n + 1, 70);
    score = 127;
    tick();
    check("level12", level, 12);
    wait_valid(200, n); tick();
    wait_valid(200, n);
    check("interval_l12", n + 1, 20);

    // Gravity wrap coinciding with acceptance of a gravity command
    cmd_ready = 0;
    n = 0;
    while (!(m_since == m_per - 1) && n < 100) begin tick(); n++; end
    cmd_ready = 1;
    tick();
    check("coinc_gap", cmd_valid, 0);
    tick();
    check("coinc_valid", cmd_valid, 1);
    check("coinc_cmd", cmd, 5);

    // Back to level 0, then left and up together against a stalled consumer
    score = 0;
    tick();
    wait_valid(200, n); tick();
    wait_valid(200, n); tick();
    repeat (3) tick();
    n0 = n_acc[1] + n_acc[3];
    cmd_ready = 0;
    left = 1; up = 1;
    tick();
    left = 0; up = 0;
    wait_valid(5, n);
    for (int i = 0; i < 5; i++) begin
      check("rot_hold", cmd, 3);
      tick();
    end
    cmd_ready = 1;
    tick();
    tick();
    check("left_after_rot", cmd, 1);
    repeat (4) tick();
    check("left_rot_once", n_acc[1] + n_acc[3] - n0, 2);

    // Hold right for 60 cycles
    repeat (5) tick();
    n0 = n_acc[2];
    right = 1;
    repeat (60) tick();
    right = 0;
    repeat (10) tick();
`ifdef AUTO_REPEAT_EN
    check("right_repeat", n_acc[2] - n0, 5);
`else
    check("right_single", n_acc[2] - n0, 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cmd_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) left  = ~left;
      if ($urandom_range(15) == 0) right = ~right;
      if ($urandom_range(15) == 0) up    = ~up;
      if ($urandom_range(15) == 0) down  = ~down;
      if ($urandom_range(199) == 0) score = 7'($urandom_range(127));
      tick();
    end
    left = 0; right = 0; up = 0; down = 0;
    cmd_ready = 1;
    repeat (5) tick();

    // Failure mid-handshake freezes everything until reset
    score = 0;
    cmd_ready = 0;
    wait_valid(200, n);
    fail = 1;
    tick();
    check("halt_valid", cmd_valid, 0);
    tick();
    fail = 0;
    n0 = n_acc[1] + n_acc[2] + n_acc[3] + n_acc[4] + n_acc[5];
    cmd_ready = 1;
    for (int i = 0; i < 500; i++) begin
      left  = ($urandom_range(3) == 0);
      right = ($urandom_range(3) == 0);
      up    = ($urandom_range(3) == 0);
      down  = ($urandom_range(3) == 0);
      tick();
    end
    left = 0; right = 0; up = 0; down = 0;
    check("halt_no_cmds", n_acc[1] + n_acc[2] + n_acc[3] + n_acc[4] + n_acc[5] - n0, 0);

    score = 127;
    rst = 1;
    tick();
    check("rst2_valid", cmd_valid, 0);
    check("rst2_cmd", cmd, 0);
    check("rst2_level", level, 0);
    rst = 0;
    wait_valid(200, n);
    check("resume_cycle", n, 101);
    check("resume_cmd", cmd, 5);
    tick();
    repeat (3) tick();

    started = 0;
    check("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
